// File: rtl/sma_level_detect.sv
// Debounced two-threshold level detector for the output of an SMA filter.
// A level change needs DEBOUNCE consecutive valid samples beyond the relevant
// threshold (strict signed compare); samples inside the band reset the run.
// Rising transitions are counted in a saturating counter with a sticky flag.
module sma_level_detect #(
    parameter int DEBOUNCE  = 4,  // 1..15
    parameter int CNT_WIDTH = 8   // 2..16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_valid,
    input  logic signed [15:0]   x,
    input  logic signed [15:0]   th_hi,
    input  logic signed [15:0]   th_lo,
    input  logic                 clr_cnt,
    output logic                 level,
    output logic                 rise,
    output logic                 fall,
    output logic [CNT_WIDTH-1:0] event_cnt,
    output logic                 cnt_sat
);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } state_t;

    localparam logic [3:0]           DB      = 4'(DEBOUNCE);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t     state, state_nx;
    logic [3:0] db_cnt, db_cnt_nx;
    logic       go_hi, go_lo;
    logic       q_hi, q_lo;

    // Both operands are signed, so these are signed 16-bit comparisons.
    assign q_hi = x_valid && (x > th_hi);
    assign q_lo = x_valid && (x < th_lo);

    // Next-state and debounce-count logic; invalid cycles hold everything.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nx  = state;
        db_cnt_nx = db_cnt;
        go_hi     = 1'b0;
        go_lo     = 1'b0;
        if (x_valid) begin
            case (state)
                LOW: begin
                    if (q_hi) begin
                        if (DB == 4'd1) begin
                            state_nx  = HIGH;
                            db_cnt_nx = '0;
                            go_hi     = 1'b1;
                        end else begin
                            state_nx  = ARM_HI;
                            db_cnt_nx = 4'd1;
                        end
                    end
                end
                ARM_HI: begin
                    if (q_hi) begin
                        if (db_cnt + 4'd1 == DB) begin
                            state_nx  = HIGH;
                            db_cnt_nx = '0;
                            go_hi     = 1'b1;
                        end else begin
                            db_cnt_nx = db_cnt + 4'd1;
                        end
                    end else begin
                        state_nx  = LOW;
                        db_cnt_nx = '0;
                    end
                end
                HIGH: begin
                    if (q_lo) begin
                        if (DB == 4'd1) begin
                            state_nx  = LOW;
                            db_cnt_nx = '0;
                            go_lo     = 1'b1;
                        end else begin
                            state_nx  = ARM_LO;
                            db_cnt_nx = 4'd1;
                        end
                    end
                end
                ARM_LO: begin
                    if (q_lo) begin
                        if (db_cnt + 4'd1 == DB) begin
                            state_nx  = LOW;
                            db_cnt_nx = '0;
                            go_lo     = 1'b1;
                        end else begin
                            db_cnt_nx = db_cnt + 4'd1;
                        end
                    end else begin
                        state_nx  = HIGH;
                        db_cnt_nx = '0;
                    end
                end
                default: begin
                    state_nx  = LOW;
                    db_cnt_nx = '0;
                end
            endcase
        end
    end

    // State register plus registered level and one-cycle edge pulses.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state  <= LOW;
            db_cnt <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            state  <= state_nx;
            db_cnt <= db_cnt_nx;
            level  <= (state_nx == HIGH) || (state_nx == ARM_LO);
            rise   <= go_hi;
            fall   <= go_lo;
        end
    end

    // Saturating rise counter; clear wins over a same-edge increment.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            event_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (go_hi && (event_cnt != CNT_MAX)) begin
            event_cnt <= event_cnt + CNT_ONE;
            if (event_cnt + CNT_ONE == CNT_MAX) begin
                cnt_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sma_level_detect.sv
// Bench for sma_level_detect: three instances (default, 2-bit counter,
// DEBOUNCE=1) share one directed stimulus. A run-length model predicts every
// output each cycle; literal checks pin the model to hand-derived values.
module tb_sma_level_detect;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, x_valid, clr_cnt;
    logic signed [15:0] x, th_hi, th_lo;
    logic [2:0]         lv, rs, fl, st;
    logic [7:0]         ev0, ev2;
    logic [1:0]         ev1;
    int                 ev_act[3];

    int total = 0;
    int bad   = 0;

    sma_level_detect #(.DEBOUNCE(4), .CNT_WIDTH(8)) u0 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .th_hi(th_hi), .th_lo(th_lo),
        .clr_cnt(clr_cnt), .level(lv[0]), .rise(rs[0]), .fall(fl[0]),
        .event_cnt(ev0), .cnt_sat(st[0]));

    sma_level_detect #(.DEBOUNCE(4), .CNT_WIDTH(2)) u1 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .th_hi(th_hi), .th_lo(th_lo),
        .clr_cnt(clr_cnt), .level(lv[1]), .rise(rs[1]), .fall(fl[1]),
        .event_cnt(ev1), .cnt_sat(st[1]));

    sma_level_detect #(.DEBOUNCE(1), .CNT_WIDTH(8)) u2 (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .th_hi(th_hi), .th_lo(th_lo),
        .clr_cnt(clr_cnt), .level(lv[2]), .rise(rs[2]), .fall(fl[2]),
        .event_cnt(ev2), .cnt_sat(st[2]));

    always_comb begin
        ev_act[0] = int'(ev0);
        ev_act[1] = int'(ev1);
        ev_act[2] = int'(ev2);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a level flips after db consecutive valid samples
    // strictly beyond the opposite threshold; any other valid sample restarts.
    int db[3]   = '{4, 4, 1};
    int cmax[3] = '{255, 3, 255};
    int m_run[3], m_cnt[3];
    bit m_lvl[3], m_rise[3], m_fall[3], m_sat[3];
    bit chk_en = 1'b0;

    // Compare against the model at each falling edge, then advance the model
    // with the inputs the next rising edge will sample.
    initial begin
        bit want;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("u%0d_level", i), int'(lv[i]), int'(m_lvl[i]));
                    check($sformatf("u%0d_rise", i),  int'(rs[i]), int'(m_rise[i]));
                    check($sformatf("u%0d_fall", i),  int'(fl[i]), int'(m_fall[i]));
                    check($sformatf("u%0d_cnt", i),   ev_act[i],   m_cnt[i]);
                    check($sformatf("u%0d_sat", i),   int'(st[i]), int'(m_sat[i]));
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    m_lvl[i] = 0; m_run[i] = 0; m_rise[i] = 0;
                    m_fall[i] = 0; m_cnt[i] = 0; m_sat[i] = 0;
                end else begin
                    m_rise[i] = 0;
                    m_fall[i] = 0;
                    if (x_valid) begin
                        want = m_lvl[i] ? (x < th_lo) : (x > th_hi);
                        if (want) begin
                            m_run[i]++;
                            if (m_run[i] == db[i]) begin
                                m_run[i] = 0;
                                m_lvl[i] = !m_lvl[i];
                                if (m_lvl[i]) m_rise[i] = 1;
                                else          m_fall[i] = 1;
                            end
                        end else begin
                            m_run[i] = 0;
                        end
                    end
                    if (clr_cnt) begin
                        m_cnt[i] = 0;
                        m_sat[i] = 0;
                    end else if (m_rise[i] && m_cnt[i] < cmax[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == cmax[i]) m_sat[i] = 1;
                    end
                end
            end
            if (rst) chk_en = 1'b1;
        end
    end

    // One clock cycle with the given inputs; returns just after the edge.
    task automatic step(input logic v, input logic signed [15:0] val, input logic c = 1'b0);
        x_valid = v;
        x       = val;
        clr_cnt = c;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        clr_cnt = 1'b0;
    endtask

    task automatic samp(input logic signed [15:0] val, input int n);
        for (int k = 0; k < n; k++) step(1'b1, val);
    endtask

    task automatic do_reset(input logic signed [15:0] hi, input logic signed [15:0] lo);
        rst   = 1'b1;
        th_hi = hi;
        th_lo = lo;
        step(1'b0, 16'sd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; x_valid = 1'b0; x = '0; clr_cnt = 1'b0;
        th_hi = 16'sd100; th_lo = 16'sd50;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_level", int'(lv[0]), 0);
        check("rst_cnt",   int'(ev0),   0);
        check("rst_sat",   int'(st[0]), 0);

        // Four qualifying samples raise the level one cycle after the 4th.
        samp(16'sd101, 3);
        check("no_early_level", int'(lv[0]), 0);
        check("db1_direct_high", int'(lv[2]), 1);
        samp(16'sd101, 1);
        check("rise_level", int'(lv[0]), 1);
        check("rise_pulse", int'(rs[0]), 1);
        check("rise_cnt",   int'(ev0),   1);
        step(1'b0, 16'sd0);
        check("rise_one_cycle", int'(rs[0]), 0);

        samp(16'sd49, 4);
        check("fall_pulse", int'(fl[0]), 1);

        // A band sample mid-run restarts the debounce.
        samp(16'sd101, 3);
        samp(16'sd75, 1);
        samp(16'sd101, 1);
        check("interrupted_level", int'(lv[0]), 0);
        samp(16'sd101, 3);
        check("restart_rise", int'(rs[0]), 1);
        check("restart_cnt",  int'(ev0),   2);

        // Gaps of invalid cycles leave the partial count intact.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'sd49);
            if (k < 3) repeat (3) step(1'b0, 16'sd0);
        end
        check("gap_fall", int'(fl[0]), 1);

        // Exactly-at-threshold samples never qualify.
        samp(16'sd100, 20);
        samp(16'sd50, 20);
        check("band_low_hold", int'(lv[0]), 0);
        samp(16'sd101, 4);
        check("third_rise_cnt", int'(ev0), 3);
        check("narrow_cnt_max", int'(ev1), 3);
        samp(16'sd100, 20);
        samp(16'sd50, 20);
        check("band_high_hold", int'(lv[0]), 1);

        // Fourth rise saturates the 2-bit counter.
        samp(16'sd49, 4);
        samp(16'sd101, 4);
        check("sat_cnt",  int'(ev1),   3);
        check("sat_flag", int'(st[1]), 1);
        check("wide_cnt", int'(ev0),   4);

        // Clear on the same edge as a rise wins; the rise still pulses.
        samp(16'sd49, 4);
        samp(16'sd101, 3);
        step(1'b1, 16'sd101, 1'b1);
        check("clr_rise",     int'(rs[0]), 1);
        check("clr_cnt_wide", int'(ev0),   0);
        check("clr_cnt_sat",  int'(ev1),   0);
        check("clr_flag",     int'(st[1]), 0);

        // Reset while high drops the level without a fall pulse.
        rst = 1'b1;
        step(1'b0, 16'sd0);
        rst = 1'b0;
        check("rst_high_level", int'(lv[0]), 0);
        check("rst_high_fall",  int'(fl[0]), 0);

        // Reset mid-debounce discards the partial count.
        samp(16'sd101, 2);
        rst = 1'b1;
        step(1'b1, 16'sd101);
        rst = 1'b0;
        check("rst_arm_level", int'(lv[0]), 0);
        check("rst_arm_rise",  int'(rs[0]), 0);
        samp(16'sd101, 3);
        check("post_rst_no_rise", int'(lv[0]), 0);
        samp(16'sd101, 1);
        check("post_rst_rise", int'(rs[0]), 1);
        check("post_rst_cnt",  int'(ev0),   1);

        // Negative thresholds exercise signed comparison.
        do_reset(-16'sd10, -16'sd100);
        samp(-16'sd5, 4);
        check("signed_high", int'(lv[0]), 1);
        samp(16'sh8000, 4);
        check("signed_fall", int'(fl[0]), 1);

        // Inverted thresholds: a value between them qualifies both ways.
        do_reset(16'sd10, 16'sd20);
        samp(16'sd15, 4);
        check("inv_rise", int'(rs[0]), 1);
        samp(16'sd15, 4);
        check("inv_fall", int'(fl[0]), 1);

        step(1'b0, 16'sd0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
